operand_collector: RTL

OPERAND_COLLECTOR -- requirements
Module: operand_collector

---
 rtl/operand_collector.sv | 130 +++++++++++++
 1 files changed

// File: rtl/operand_collector.sv
// Operand collector: gathers up to N_OPS write-once operands for one issue,
// then presents them to a consumer under an ops_valid/ops_ready handshake.
module operand_collector #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned N_OPS     = 5
) (
  input  logic                                clk,
  input  logic                                n_reset,
  input  logic                                start,
  input  logic [N_OPS-1:0]                    need_mask,
  input  logic [N_OPS-1:0]                    reg_en,
  input  logic [N_OPS-1:0][BUS_WIDTH-1:0]     ops,
  input  logic                                flush,
  input  logic                                ops_ready,
  output logic [N_OPS-1:0][BUS_WIDTH-1:0]     ops_reg,
  output logic                                ops_valid,
  output logic [N_OPS-1:0]                    loaded,
  output logic                                busy,
  output logic                                overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_OPS-1:0] req_mask;
  logic [N_OPS-1:0] req_mask_nxt;
  logic [N_OPS-1:0] loaded_nxt;
  logic [N_OPS-1:0] wr_en;
  logic [N_OPS-1:0] accept;
  logic             overrun_nxt;
  logic             begin_col;

  // Next-state and datapath control; flush overrides every other input.
  always_comb begin
    state_nxt    = state;
    req_mask_nxt = req_mask;
    loaded_nxt   = loaded;
    overrun_nxt  = overrun;
    wr_en        = '0;
    begin_col    = 1'b0;
    accept       = reg_en & ~loaded;

    if (flush) begin
      state_nxt  = IDLE;
      loaded_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            begin_col = 1'b1;
          end else begin
            // Pre-loading while idle updates data but does not mark channels.
            wr_en = reg_en;
          end
        end
        COLLECT: begin
          wr_en      = accept;
          loaded_nxt = loaded | accept;
          if (|(reg_en & loaded)) begin
            overrun_nxt = 1'b1;
          end
          if ((loaded_nxt & req_mask) == req_mask) begin
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          if (ops_ready) begin
            if (start) begin
              begin_col = 1'b1;
            end else begin
              state_nxt  = IDLE;
              loaded_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt  = IDLE;
          loaded_nxt = '0;
        end
      endcase
    end

    // A honoured start opens a fresh collection and keeps same-cycle loads.
    if (begin_col) begin
      state_nxt    = COLLECT;
      req_mask_nxt = need_mask;
      loaded_nxt   = reg_en;
      wr_en        = reg_en;
      overrun_nxt  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and collection bookkeeping.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      req_mask  <= '0;
      loaded    <= '0;
      overrun   <= 1'b0;
      ops_valid <= 1'b0;
      busy      <= 1'b0;
      ops_reg   <= '0;
    end else begin
      req_mask  <= req_mask_nxt;
      loaded    <= loaded_nxt;
      overrun   <= overrun_nxt;
      ops_valid <= (state_nxt == ISSUE);
      busy      <= (state_nxt != IDLE);
      for (int unsigned i = 0; i < N_OPS; i++) begin
        if (wr_en[i]) begin
          ops_reg[i] <= ops[i];
        end
      end
    end
  end

endmodule
